decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I instruction decoder that produces the `alu_op` encoding, operand selects, immediate, register indices and control strobes consumed by the ALU and surrounding datapath. It is the producer end of the `alu_op` interface, sitting between instruction fetch and the ALU/register-file stage. Valid/ready handshakes on both sides make it usable as a pipeline stage.

## Interface
- `XLEN`, 32: data and immediate width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_instr` and `in_pc` are valid.
- `in_ready`  out  1  stage can accept an instruction.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  32  PC of the instruction.
- `out_valid`  out  1  decoded bundle is valid.
- `out_ready`  in  1  downstream accepts the bundle.
- `out_pc`  out  32  PC passed through.
- `alu_op`  out  4  ALU operation code:
  - 0000 add, 0001 sub, 0010 slt, 0011 sltu, 0100 sll, 0101 xor
  - 0110 srl, 0111 sra, 1000 or, 1001 and, 1010 nop, 1011 bge
- `alu_src_a_pc`  out  1  ALU A operand = PC (AUIPC, JAL).
- `alu_src_b_imm`  out  1  ALU B operand = `imm`.
- `imm`  out  32  sign-extended immediate (I/S/B/U/J formats). Shift-immediates use `{27'b0, instr[24:20]}`.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  register indices.
- `reg_write`, `mem_read`, `mem_write`  out  1 each  control strobes.
- `branch`  out  1  conditional branch; taken = ALU zero flag XOR `branch_inv`.
- `branch_inv`  out  1  invert the taken sense.
- `jump`  out  1  JAL/JALR.
- `jalr`  out  1  target comes from rs1+imm.
- `illegal`  out  1  unsupported encoding.

## Operation
- Decoding is combinational from `in_instr`. The bundle is captured on handshake (`in_valid && in_ready`).
- R/I ALU ops map directly onto `alu_op`:
  - SUB and SRA/SRAI require funct7 = 0100000.
  - All other R-type ops and SLLI/SRLI require funct7 = 0000000; any other funct7 sets `illegal`.
- LUI: `alu_op`=add, `rs1_addr`=0, `alu_src_b_imm`=1.
- AUIPC: add, `alu_src_a_pc`=1.
- Loads and stores: add with imm.
  - Loads set `mem_read` and `reg_write`.
  - Stores set `mem_write`, use the S-type immediate, and force `rd_addr`=0.
- JAL: add, `alu_src_a_pc`=1, `imm`=4, `jump`=1, `reg_write`=1. The J-immediate is not used.
- JALR: same as JAL, plus `jalr`=1. The I-immediate is not used; the target adder uses rs1 + I-immediate.
- Branches (`branch`=1, B-immediate, `reg_write`=0):

  | Branch | `alu_op` | `branch_inv` |
  |---|---|---|
  | BEQ | sub | 0 |
  | BNE | sub | 1 |
  | BLT | slt | 1 |
  | BGE | bge | 1 |
  | BLTU | sltu | 1 |
  | BGEU | sltu | 0 |

- FENCE: nop, all strobes 0, `illegal`=0.
- SYSTEM and any unknown opcode: `alu_op`=nop, all strobes 0, `illegal`=1.
- Any instruction with rd=x0 forces `reg_write`=0.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- While `out_valid && !out_ready`, every output is held stable. `out_valid` never drops without a handshake.
- Reset values, applied on the first `clk` edge with `rst_n`=0:
  - `out_valid`=0 and `in_ready`=0 while in reset.
  - `alu_op`=1010 (nop).
  - All other outputs 0.
- Reset mid-operation discards every buffered entry. No handshake completes on a reset cycle.
- Simultaneous input and output handshake in the same cycle: the new bundle replaces the old one with no bubble.

## Configuration
- `DECODE_SKID_EN` defined:
  - A 2-entry skid buffer sits between the decoder and the outputs.
  - `in_ready` is a register output, equal to "skid entry empty".
  - There is no combinational path from `out_ready` to `in_ready`.
  - Full throughput is sustained.
- `DECODE_SKID_EN` undefined:
  - A single output register is used.
  - `in_ready` = `!out_valid || out_ready`, which is combinational.
  - Throughput and latency are unchanged.

## Structure
- Shared package `rv_pkg` holds:
  - `alu_op` localparams (ALU_ADD … ALU_BGE, ALU_NOP = 4'b1010).
  - RV32I opcode constants.
  - The packed decoded-bundle struct typedef.
- Sub-module `decode_skid_buf` is a generic 2-entry valid/ready buffer, parameterised on payload width. It is instantiated only under `DECODE_SKID_EN`.
- Immediate generation and opcode decode stay inline as combinational logic.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 → `out_valid`=0, `alu_op`=1010, `in_ready`=0 throughout.
- `add x3,x1,x2` (0x002081B3) → one cycle later:
  - `alu_op`=0000, `alu_src_b_imm`=0.
  - rs1=1, rs2=2, rd=3, `reg_write`=1.
- `srai x5,x6,3` (0x40335293) → `alu_op`=0111, `imm`=0x00000003. `slli` with funct7=0100000 (0x40031293) → `illegal`=1, `alu_op`=1010.
- `bge x1,x2,-8` (0xFE20DCE3) → `alu_op`=1011, `imm`=0xFFFFFFF8, `branch`=1, `branch_inv`=1, `reg_write`=0. `bgeu` → `alu_op`=0011, `branch_inv`=0.
- Backpressure: stream 8 instructions with `out_ready` low on cycles 2–4 → all 8 emerge in order, none dropped or duplicated, outputs stable while stalled. Run with and without `DECODE_SKID_EN`.
- `addi x0,x0,0` and `ecall` (0x00000073) → NOP has `reg_write`=0 and `illegal`=0; ECALL has `illegal`=1 and all strobes 0.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, alu_op codes and the decoded bundle shared by
// the decode stage and its consumers.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_NOP  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_inv;
    logic            jump;
    logic            jalr;
    logic            illegal;
  } dec_t;

  function automatic dec_t dec_rst();
    dec_t d;
    d = '0;
    d.alu_op = ALU_NOP;
    return d;
  endfunction

  localparam dec_t DEC_RST = dec_rst();

  // alt selects SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_of(
    logic [2:0] f3,
    logic       alt
  );
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and ALU-side valid/ready bundle of the
// decode stage; slave is the decoder, master is its environment.
interface decode_stage_if;
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      alu_op;
  logic            alu_src_a_pc;
  logic            alu_src_b_imm;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            branch_inv;
  logic            jump;
  logic            jalr;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, alu_op,
    output alu_src_a_pc, alu_src_b_imm, imm,
    output rs1_addr, rs2_addr, rd_addr,
    output reg_write, mem_read, mem_write,
    output branch, branch_inv, jump, jalr, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, alu_op,
    input  alu_src_a_pc, alu_src_b_imm, imm,
    input  rs1_addr, rs2_addr, rd_addr,
    input  reg_write, mem_read, mem_write,
    input  branch, branch_inv, jump, jalr, illegal
  );

endinterface

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: 2-entry valid/ready buffer; in_ready is registered
// so there is no combinational out_ready -> in_ready path.
module decode_skid_buf #(
  parameter int           W   = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         rdy_q;
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         main_free;
  logic         in_fire;
  logic         skid_v_nx;

  assign in_ready  = rdy_q;
  assign main_free = !out_valid || out_ready;
  assign in_fire   = in_valid && rdy_q;

  // rdy_q mirrors the skid slot being empty, one cycle ahead
  always_comb begin
    skid_v_nx = skid_v;
    if (main_free) skid_v_nx = 1'b0;
    else if (in_fire) skid_v_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= RST;
      skid_v    <= 1'b0;
      skid_d    <= RST;
      rdy_q     <= 1'b0;
    end else begin
      skid_v <= skid_v_nx;
      rdy_q  <= !skid_v_nx;
      if (main_free) begin
        if (skid_v) begin
          out_data  <= skid_d;
          out_valid <= 1'b1;
        end else if (in_fire) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder feeding the ALU stage.
// DECODE_SKID_EN selects a 2-entry skid buffer instead of one register.
module decode_stage
  import rv_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  logic [31:0]     ins;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f7_zero;
  logic            f7_alt;
  logic            ill;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  dec_t            d;
  dec_t            q;

  assign ins     = bus.in_instr;
  assign opc     = ins[6:0];
  assign f3      = ins[14:12];
  assign f7      = ins[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  assign imm_i   = {{20{ins[31]}}, ins[31:20]};
  assign imm_s   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b   = {{19{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
  assign imm_u   = {ins[31:12], 12'b0};

  always_comb begin
    d        = '0;
    d.pc     = bus.in_pc;
    d.alu_op = ALU_NOP;
    d.rs1    = ins[19:15];
    d.rs2    = ins[24:20];
    d.rd     = ins[11:7];
    ill      = 1'b0;
    unique case (1'b1)
      opc == OP_OP: begin
        d.alu_op    = alu_of(f3, f7[5]);
        d.reg_write = 1'b1;
        ill = !(f7_zero ||
                (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
      end
      opc == OP_IMM: begin
        d.alu_op    = alu_of(f3, f3 == 3'b101 && f7[5]);
        d.src_b_imm = 1'b1;
        d.reg_write = 1'b1;
        d.imm = (f3 == 3'b001 || f3 == 3'b101)
              ? {27'b0, ins[24:20]} : imm_i;
        ill = (f3 == 3'b001 && !f7_zero) ||
              (f3 == 3'b101 && !f7_zero && !f7_alt);
      end
      opc == OP_LUI: begin
        d.alu_op    = ALU_ADD;
        d.rs1       = 5'd0;
        d.src_b_imm = 1'b1;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
      end
      opc == OP_AUIPC: begin
        d.alu_op    = ALU_ADD;
        d.src_a_pc  = 1'b1;
        d.src_b_imm = 1'b1;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
      end
      opc == OP_LOAD: begin
        d.alu_op    = ALU_ADD;
        d.src_b_imm = 1'b1;
        d.imm       = imm_i;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      opc == OP_STORE: begin
        d.alu_op    = ALU_ADD;
        d.src_b_imm = 1'b1;
        d.imm       = imm_s;
        d.mem_write = 1'b1;
        d.rd        = 5'd0;
        ill = f3[2] || (f3 == 3'b011);
      end
      // ALU computes the link value pc+4; the target adder is separate
      opc == OP_JAL || opc == OP_JALR: begin
        d.alu_op    = ALU_ADD;
        d.src_a_pc  = 1'b1;
        d.src_b_imm = 1'b1;
        d.imm       = 32'd4;
        d.jump      = 1'b1;
        d.jalr      = (opc == OP_JALR);
        d.reg_write = 1'b1;
        ill = (opc == OP_JALR) && (f3 != 3'b000);
      end
      opc == OP_BRANCH: begin
        d.branch = 1'b1;
        d.imm    = imm_b;
        case (f3)
          3'b000: d.alu_op = ALU_SUB;
          3'b001: begin
            d.alu_op     = ALU_SUB;
            d.branch_inv = 1'b1;
          end
          3'b100: begin
            d.alu_op     = ALU_SLT;
            d.branch_inv = 1'b1;
          end
          3'b101: begin
            d.alu_op     = ALU_BGE;
            d.branch_inv = 1'b1;
          end
          3'b110: begin
            d.alu_op     = ALU_SLTU;
            d.branch_inv = 1'b1;
          end
          3'b111: d.alu_op = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      opc == OP_FENCE: begin
        d.alu_op = ALU_NOP;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d.alu_op     = ALU_NOP;
      d.src_a_pc   = 1'b0;
      d.src_b_imm  = 1'b0;
      d.imm        = '0;
      d.reg_write  = 1'b0;
      d.mem_read   = 1'b0;
      d.mem_write  = 1'b0;
      d.branch     = 1'b0;
      d.branch_inv = 1'b0;
      d.jump       = 1'b0;
      d.jalr       = 1'b0;
    end
    d.illegal = ill;
    if (d.rd == 5'd0) d.reg_write = 1'b0;
  end

`ifdef DECODE_SKID_EN
  decode_skid_buf #(
    .W   ($bits(dec_t)),
    .RST (DEC_RST)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (d),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (q)
  );
`else
  logic v_q;
  dec_t q_r;

  assign bus.in_ready  = rst_n && (!v_q || bus.out_ready);
  assign bus.out_valid = v_q;
  assign q             = q_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      q_r <= DEC_RST;
    end else if (bus.in_valid && bus.in_ready) begin
      v_q <= 1'b1;
      q_r <= d;
    end else if (bus.out_ready) begin
      v_q <= 1'b0;
    end
  end
`endif

  assign bus.out_pc        = q.pc;
  assign bus.alu_op        = q.alu_op;
  assign bus.alu_src_a_pc  = q.src_a_pc;
  assign bus.alu_src_b_imm = q.src_b_imm;
  assign bus.imm           = q.imm;
  assign bus.rs1_addr      = q.rs1;
  assign bus.rs2_addr      = q.rs2;
  assign bus.rd_addr       = q.rd;
  assign bus.reg_write     = q.reg_write;
  assign bus.mem_read      = q.mem_read;
  assign bus.mem_write     = q.mem_write;
  assign bus.branch        = q.branch;
  assign bus.branch_inv    = q.branch_inv;
  assign bus.jump          = q.jump;
  assign bus.jalr          = q.jalr;
  assign bus.illegal       = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; expected bundles
// are hand-decoded constants queued on input handshake.
module tb_decode_stage;
  import rv_pkg::*;

  localparam logic [7:0] F_RW = 8'h80;
  localparam logic [7:0] F_MR = 8'h40;
  localparam logic [7:0] F_MW = 8'h20;
  localparam logic [7:0] F_BR = 8'h10;
  localparam logic [7:0] F_BI = 8'h08;
  localparam logic [7:0] F_J  = 8'h04;
  localparam logic [7:0] F_JR = 8'h02;
  localparam logic [7:0] F_IL = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  dec_t sb[$];

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic dec_t ex(
    logic [31:0] pc, logic [3:0] op, logic ap, logic bimm,
    logic [31:0] imm, logic [4:0] r1, logic [4:0] r2,
    logic [4:0] rd, logic [7:0] f
  );
    dec_t e;
    e.pc = pc; e.alu_op = op; e.src_a_pc = ap;
    e.src_b_imm = bimm; e.imm = imm;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd;
    {e.reg_write, e.mem_read, e.mem_write, e.branch,
     e.branch_inv, e.jump, e.jalr, e.illegal} = f;
    return e;
  endfunction

  function automatic dec_t act();
    dec_t a;
    a.pc = bus.out_pc; a.alu_op = bus.alu_op;
    a.src_a_pc = bus.alu_src_a_pc;
    a.src_b_imm = bus.alu_src_b_imm; a.imm = bus.imm;
    a.rs1 = bus.rs1_addr; a.rs2 = bus.rs2_addr;
    a.rd = bus.rd_addr;
    {a.reg_write, a.mem_read, a.mem_write, a.branch,
     a.branch_inv, a.jump, a.jalr, a.illegal} =
    {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch,
     bus.branch_inv, bus.jump, bus.jalr, bus.illegal};
    return a;
  endfunction

  // one instruction in, wait for its bundle; no comparison here
  task automatic xfer(
    input logic [31:0] ins, input logic [31:0] pc,
    input dec_t e, output dec_t a, output dec_t x,
    output bit ok
  );
    ok = 1'b0; a = '0; x = e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin ok = 1'b1; break; end
      end
    end
    if (ok && sb.size() > 0) begin
      a = act(); x = sb.pop_front();
    end else ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1;
    bus.in_instr = 32'h002081B3; bus.in_pc = 32'h0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.alu_op} !== {2'b00, ALU_NOP}) begin
        errors++;
        $display("FAIL reset cyc%0d got v=%b r=%b op=%b want v=0 r=0 op=1010",
                 c, bus.out_valid, bus.in_ready, bus.alu_op);
      end
    end
    checks++;
    if (act() !== DEC_RST) begin
      errors++;
      $display("FAIL reset_bundle got=%h want=%h", act(), DEC_RST);
    end
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_add();
    dec_t a, x; bit ok;
    xfer(32'h002081B3, 32'h100,
         ex(32'h100, ALU_ADD, 0, 0, 0, 1, 2, 3, F_RW), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL add ok=%b got=%h want=%h", ok, a, x);
    end
  endtask

  task automatic test_shift();
    dec_t a, x; bit ok;
    xfer(32'h40335293, 32'h104,
         ex(32'h104, ALU_SRA, 0, 1, 3, 6, 3, 5, F_RW), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL srai ok=%b got=%h want=%h", ok, a, x);
    end
    xfer(32'h40031293, 32'h108,
         ex(32'h108, ALU_NOP, 0, 0, 0, 6, 0, 5, F_IL), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL slli_bad ok=%b got=%h want=%h", ok, a, x);
    end
  endtask

  task automatic test_branch();
    dec_t a, x; bit ok;
    xfer(32'hFE20DCE3, 32'h10C,
         ex(32'h10C, ALU_BGE, 0, 0, 32'hFFFFFFF8, 1, 2, 25,
            F_BR | F_BI), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL bge ok=%b got=%h want=%h", ok, a, x);
    end
    xfer(32'hFE20FCE3, 32'h110,
         ex(32'h110, ALU_SLTU, 0, 0, 32'hFFFFFFF8, 1, 2, 25,
            F_BR), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL bgeu ok=%b got=%h want=%h", ok, a, x);
    end
  endtask

  task automatic test_nop_ecall();
    dec_t a, x; bit ok;
    xfer(32'h00000013, 32'h114,
         ex(32'h114, ALU_ADD, 0, 1, 0, 0, 0, 0, 8'h00), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL nop ok=%b got=%h want=%h", ok, a, x);
    end
    xfer(32'h00000073, 32'h118,
         ex(32'h118, ALU_NOP, 0, 0, 0, 0, 0, 0, F_IL), a, x, ok);
    checks++;
    if (!ok || a !== x) begin
      errors++; $display("FAIL ecall ok=%b got=%h want=%h", ok, a, x);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [8];
    dec_t exs [8];
    dec_t a, x, held;
    bit held_v;
    int sent, got;
    ins = '{32'h002081B3, 32'h40335293, 32'h12345237,
            32'h0020A423, 32'hFFC0A283, 32'h010000EF,
            32'h00008067, 32'h00001317};
    exs[0] = ex(32'h200, ALU_ADD, 0, 0, 0, 1, 2, 3, F_RW);
    exs[1] = ex(32'h204, ALU_SRA, 0, 1, 3, 6, 3, 5, F_RW);
    exs[2] = ex(32'h208, ALU_ADD, 0, 1, 32'h12345000, 0, 3, 4, F_RW);
    exs[3] = ex(32'h20C, ALU_ADD, 0, 1, 8, 1, 2, 0, F_MW);
    exs[4] = ex(32'h210, ALU_ADD, 0, 1, 32'hFFFFFFFC, 1, 28, 5,
                F_MR | F_RW);
    exs[5] = ex(32'h214, ALU_ADD, 1, 1, 4, 0, 16, 1, F_J | F_RW);
    exs[6] = ex(32'h218, ALU_ADD, 1, 1, 4, 1, 0, 0, F_J | F_JR);
    exs[7] = ex(32'h21C, ALU_ADD, 1, 1, 32'h1000, 0, 0, 6, F_RW);
    sb.delete();
    held_v = 1'b0; sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c <= 4);
      #1;
      if (held_v) begin
        checks++;
        if (!bus.out_valid || act() !== held) begin
          errors++;
          $display("FAIL stall_hold cyc%0d v=%b got=%h want=%h",
                   c, bus.out_valid, act(), held);
        end
      end
      held_v = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          a = act(); checks++; got++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL stream_extra got=%h want=none", a);
          end else begin
            x = sb.pop_front();
            if (a !== x) begin
              errors++;
              $display("FAIL stream#%0d got=%h want=%h", got - 1, a, x);
            end
          end
        end else begin
          held = act(); held_v = 1'b1;
        end
      end
      if (sent < 8) begin
        bus.in_valid = 1'b1; bus.in_instr = ins[sent];
        bus.in_pc = exs[sent].pc;
      end else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(exs[sent]); sent++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    checks++;
    if (got != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count got=%0d left=%0d want=8 left=0",
               got, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3;
      bus.in_pc = 32'h300 + 32'(c * 4);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_stall_valid got=%b want=1", bus.out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.alu_op} !== {2'b00, ALU_NOP}) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b op=%b want v=0 r=0 op=1010",
               bus.out_valid, bus.in_ready, bus.alu_op);
    end
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_flush cyc%0d got v=%b want 0", c, bus.out_valid);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_shift();
    test_branch();
    test_nop_ecall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
